// File: rtl/opb_register_bank_pkg.sv
// rtl/opb_register_bank_pkg.sv - shared types, word map constants and BE mask helper
package opb_register_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RECOVER = 2'd2
    } opb_state_t;

    localparam int READBACK_WORD = 32;
    localparam int CTRL_WORD     = 63;

    // OPB is big-endian: BE[0] covers DBus[0:7], which is register bits 31:24
    function automatic logic [31:0] be_to_mask(input logic [0:3] be);
        return {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    endfunction

endpackage

// File: rtl/opb_be_merge.sv
// rtl/opb_be_merge.sv - byte-enable merge of old register value with bus write data
module opb_be_merge #(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_WIDTH-1:0] old_value,
    input  logic [31:0]          bus_data,
    input  logic [0:3]           be,
    output logic [REG_WIDTH-1:0] merged
);
    import opb_register_bank_pkg::*;

    logic [31:0] mask;
    logic [31:0] old_ext;
    logic [31:0] full;
    logic        unused_bits;

    // Widen the stored value so the merge is done on a full bus word
    always_comb begin
        old_ext                  = '0;
        old_ext[REG_WIDTH-1:0]   = old_value;
    end

    assign mask        = be_to_mask(be);
    assign full        = (old_ext & ~mask) | (bus_data & mask);
    // Bits above the register width are dropped here
    assign merged      = full[REG_WIDTH-1:0];
    assign unused_bits = ^full;

endmodule

// File: rtl/opb_register_bank.sv
// rtl/opb_register_bank.sv - OPB software register bank with staged/active pairs and commit
module opb_register_bank #(
    parameter logic [31:0] C_BASEADDR      = 32'h0100_8200,
    parameter logic [31:0] C_HIGHADDR      = 32'h0100_82FF,
    parameter int          C_OPB_AWIDTH    = 32,
    parameter int          C_OPB_DWIDTH    = 32,
    parameter int          C_NUM_REGS      = 8,
    parameter int          C_REG_WIDTH     = 32,
    parameter int          C_DOUBLE_BUFFER = 1,
    parameter logic [31:0] C_RESET_VALUE   = 32'h0
) (
    input  logic                                OPB_Clk,
    input  logic                                OPB_Rst_n,
    input  logic [0:31]                         OPB_ABus,
    input  logic [0:3]                          OPB_BE,
    input  logic [0:31]                         OPB_DBus,
    input  logic                                OPB_RNW,
    input  logic                                OPB_select,
    input  logic                                OPB_seqAddr,
    output logic [0:31]                         Sl_DBus,
    output logic                                Sl_xferAck,
    output logic                                Sl_errAck,
    output logic                                Sl_retry,
    output logic                                Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0]   user_data_out,
    input  logic [C_NUM_REGS*C_REG_WIDTH-1:0]   user_data_in,
    output logic [C_NUM_REGS-1:0]               user_wr_strobe
);
    import opb_register_bank_pkg::*;

    localparam logic [C_REG_WIDTH-1:0] RST_VAL = C_RESET_VALUE[C_REG_WIDTH-1:0];

    opb_state_t             state;
    logic [31:0]            addr;
    logic [31:0]            offset;
    logic [5:0]             word;
    logic                   hit;
    logic [31:0]            rd_data;
    logic                   unused_addr;

    logic [5:0]             req_word;
    logic                   req_rnw;
    logic [0:3]             req_be;
    logic [31:0]            req_data;
    logic                   do_write;

    logic [C_REG_WIDTH-1:0] staged [C_NUM_REGS];
    logic [C_REG_WIDTH-1:0] active [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  dirty;
    logic [15:0]            commit_count;
    logic [C_REG_WIDTH-1:0] old_sel;
    logic [C_REG_WIDTH-1:0] merged;

    assign addr        = OPB_ABus;
    assign offset      = addr - C_BASEADDR;
    assign word        = offset[7:2];
    assign hit         = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign unused_addr = ^{OPB_seqAddr, offset[31:8], offset[1:0]};

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Read mux over the word map; unmapped words read zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word == 6'(i))
                rd_data[C_REG_WIDTH-1:0] = staged[i];
            if (word == 6'(READBACK_WORD + i))
                rd_data[C_REG_WIDTH-1:0] = user_data_in[i*C_REG_WIDTH +: C_REG_WIDTH];
        end
        if (word == 6'(CTRL_WORD))
            rd_data = {16'b0, commit_count};
    end

    // Bus handshake: latch the request on select, ack for one cycle, then one recovery cycle
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state      <= ST_IDLE;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            req_word   <= '0;
            req_rnw    <= 1'b1;
            req_be     <= '0;
            req_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state      <= ST_ACK;
                        Sl_xferAck <= 1'b1;
                        Sl_DBus    <= OPB_RNW ? rd_data : 32'h0;
                        req_word   <= word;
                        req_rnw    <= OPB_RNW;
                        req_be     <= OPB_BE;
                        req_data   <= OPB_DBus;
                    end
                end
                ST_ACK: begin
                    state      <= ST_RECOVER;
                    Sl_xferAck <= 1'b0;
                    Sl_DBus    <= '0;
                end
                ST_RECOVER: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign do_write = (state == ST_ACK) && !req_rnw;

    // Current staged value of the addressed register feeds the byte merge
    always_comb begin
        old_sel = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (req_word == 6'(i))
                old_sel = staged[i];
    end

    opb_be_merge #(
        .REG_WIDTH (C_REG_WIDTH)
    ) u_be_merge (
        .old_value (old_sel),
        .bus_data  (req_data),
        .be        (req_be),
        .merged    (merged)
    );

    // Register file: writes land at the edge ending ACK, commit copies staged to active
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                staged[i] <= RST_VAL;
                active[i] <= RST_VAL;
            end
            dirty          <= '0;
            user_wr_strobe <= '0;
            commit_count   <= '0;
        end else begin
            user_wr_strobe <= '0;
            if (do_write) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (req_word == 6'(i)) begin
                        staged[i] <= merged;
                        if (C_DOUBLE_BUFFER != 0) begin
                            dirty[i] <= 1'b1;
                        end else begin
                            active[i]         <= merged;
                            user_wr_strobe[i] <= 1'b1;
                        end
                    end
                end
                if (req_word == 6'(CTRL_WORD) && req_data[0]) begin
                    commit_count <= commit_count + 16'd1;
                    if (C_DOUBLE_BUFFER != 0) begin
                        for (int i = 0; i < C_NUM_REGS; i++)
                            active[i] <= staged[i];
                        user_wr_strobe <= dirty;
                        dirty          <= '0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[g*C_REG_WIDTH +: C_REG_WIDTH] = active[g];
    end

endmodule
